// File: rtl/xbus_decoder_pkg.sv
// xbus_decoder_pkg: FSM state encodings, default slot map and counter sizing for the xbus decoder
package xbus_decoder_pkg;
  typedef enum logic [1:0] {
    XBUS_IDLE = 2'd0,
    XBUS_WAIT = 2'd1,
    XBUS_DONE = 2'd2
  } xbus_state_e;
  localparam int SLOT_MEM  = 0;
  localparam int SLOT_REGF = 1;
  localparam int SLOT_EXT  = 2;
  localparam int SLOT_CPRT = 3;
  function automatic int cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/xbus_timer.sv
// xbus_timer: clear/enable saturating wait counter, expired when the count reaches TIMEOUT
module xbus_timer import xbus_decoder_pkg::*; #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = cnt_w(TIMEOUT);
  logic [CW-1:0] cnt_q;
  assign expired = cnt_q == CW'(TIMEOUT);
  always_ff @(posedge clk)
    if (rst || clr) cnt_q <= '0;
    else if (en && !expired) cnt_q <= cnt_q + CW'(1);
endmodule

// File: rtl/xbus_decoder.sv
// xbus_decoder: registered data-bus decoder with per-slave ready handshake, timeout and sticky trap
module xbus_decoder import xbus_decoder_pkg::*; #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int SLOT_W  = 11,
  parameter int N_SLV   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_sel,
  input  logic                      m_we,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_ready,
  output logic [N_SLV-1:0]          s_sel,
  output logic                      s_we,
  output logic [SLOT_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [N_SLV*DATA_W-1:0]   s_rdata,
  input  logic [N_SLV-1:0]          s_ready,
  output logic                      trap,
  output logic [ADDR_W-SLOT_W-1:0]  err_slot
);
  localparam int SW = ADDR_W - SLOT_W;
  localparam int RW = $clog2(N_SLV * DATA_W);
  xbus_state_e       state_q;
  logic [SW-1:0]     slot_q;
  logic [DATA_W-1:0] m_rdata_q;
  logic              m_ready_q;
  logic [N_SLV-1:0]  s_sel_q;
  logic              s_we_q;
  logic [SLOT_W-1:0] s_addr_q;
  logic [DATA_W-1:0] s_wdata_q;
  logic              trap_q;
  logic [SW-1:0]     err_q;
  logic [SW-1:0]     slot_in;
  logic              mapped;
  logic              rdy;
  logic              tmo;
  logic [RW-1:0]     rd_base;
  assign slot_in  = m_addr[ADDR_W-1:SLOT_W];
  assign mapped   = int'(slot_in) < N_SLV;
  assign rdy      = |(s_ready & s_sel_q);
  assign rd_base  = RW'(slot_q * DATA_W);
  assign m_rdata  = m_rdata_q;
  assign m_ready  = m_ready_q;
  assign s_sel    = s_sel_q;
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign trap     = trap_q;
  assign err_slot = err_q;
  if (TIMEOUT == 0) begin : g_no_tmo
    assign tmo = 1'b0;
  end else begin : g_tmo
    xbus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != XBUS_WAIT),
      .en      (state_q == XBUS_WAIT),
      .expired (tmo)
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= XBUS_IDLE;
      slot_q    <= '0;
      m_rdata_q <= '0;
      m_ready_q <= 1'b0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      trap_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      m_ready_q <= 1'b0;
      case (state_q)
        XBUS_IDLE: if (m_sel) begin
          slot_q    <= slot_in;
          s_we_q    <= m_we;
          s_addr_q  <= m_addr[SLOT_W-1:0];
          s_wdata_q <= m_wdata;
          if (mapped) begin
            state_q <= XBUS_WAIT;
            s_sel_q <= N_SLV'(1) << slot_in;
          end else begin
            state_q   <= XBUS_DONE;
            m_ready_q <= 1'b1;
            m_rdata_q <= '0;
            trap_q    <= 1'b1;
            if (!trap_q) err_q <= slot_in;
          end
        end
        XBUS_WAIT: if (rdy) begin
          state_q   <= XBUS_DONE;
          m_ready_q <= 1'b1;
          s_sel_q   <= '0;
          m_rdata_q <= s_we_q ? '0 : s_rdata[rd_base +: DATA_W];
        end else if (tmo) begin
          state_q   <= XBUS_DONE;
          m_ready_q <= 1'b1;
          s_sel_q   <= '0;
          m_rdata_q <= '0;
          trap_q    <= 1'b1;
          if (!trap_q) err_q <= slot_q;
        end
        default: begin
          state_q   <= XBUS_IDLE;
          m_rdata_q <= '0;
        end
      endcase
    end
endmodule

// File: doc/xbus_decoder.md
# xbus_decoder

Parametrised, registered data-bus decoder for the picoVersat data bus. It sits between the controller's data port and N_SLV slave slots (RAM, register file, external port, user peripherals). Unlike a purely combinational address decoder, it latches each request, waits for a per-slave ready handshake, and aborts on a bounded timeout. It raises a sticky trap on unmapped or timed-out accesses.

## Interface
Parameters:
- ADDR_W, 13, master address width
- DATA_W, 32, data width
- SLOT_W, 11, low address bits passed to each slave; slot index = m_addr[ADDR_W-1:SLOT_W]
- N_SLV, 4, number of mapped slots (1..2^(ADDR_W-SLOT_W)); slots ≥ N_SLV are unmapped
- TIMEOUT, 15, max cycles waiting for s_ready; 0 disables timeout

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_sel  in  1  master request valid
- m_we  in  1  1 = write, 0 = read
- m_addr  in  ADDR_W  master address
- m_wdata  in  DATA_W  write data
- m_rdata  out  DATA_W  read data, valid while m_ready=1
- m_ready  out  1  one-cycle completion pulse
- s_sel  out  N_SLV  one-hot slave select
- s_we  out  1  registered write enable
- s_addr  out  SLOT_W  registered slave offset
- s_wdata  out  DATA_W  registered write data
- s_rdata  in  N_SLV*DATA_W  slave read data; slot k at [k*DATA_W +: DATA_W]
- s_ready  in  N_SLV  slave completion, sampled only for the selected slot
- trap  out  1  sticky error flag
- err_slot  out  ADDR_W-SLOT_W  slot index of the first error

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, m_sel=1:
  - Latch slot, offset, we and wdata.
  - Mapped slot: go to WAIT, drive s_sel[slot]=1.
  - Unmapped slot: go to DONE with m_rdata=0, set trap. If trap was previously 0, record err_slot.
- WAIT:
  - s_sel, s_we, s_addr and s_wdata are held stable.
  - If s_ready[slot]=1: capture s_rdata slot (reads) or 0 (writes), go to DONE.
  - Else, if TIMEOUT≠0 and wait count = TIMEOUT: go to DONE with m_rdata=0, set trap, record err_slot if first error.
- DONE:
  - m_ready=1 for exactly one cycle; s_sel=0.
  - m_sel is ignored; return to IDLE.
- m_sel held high during WAIT/DONE is not re-accepted. A new request is accepted only in IDLE.
- The wait counter clears on entry to WAIT and saturates; its width is clog2(TIMEOUT+1).
- trap and err_slot are cleared only by rst.
- s_ready for non-selected slots and s_ready outside WAIT are ignored.

## Timing
- Reset values: state=IDLE, m_ready=0, m_rdata=0, s_sel=0, s_we=0, s_addr=0, s_wdata=0, trap=0, err_slot=0, counter=0.
- rst mid-transaction: next cycle is IDLE with all outputs at reset values. No m_ready pulse is produced for the aborted access.
- Mapped access, zero-wait slave:
  - m_sel at cycle 0.
  - s_sel at cycle 1; s_ready=1 at cycle 1.
  - m_ready and m_rdata at cycle 2.
  - Next acceptance at cycle 3 (throughput 1 per 3 cycles).
- Each wait cycle with s_ready=0 adds one cycle of latency.
- Timeout: s_sel stays high for TIMEOUT+1 cycles (cycles 1..TIMEOUT+1). m_ready pulses at cycle TIMEOUT+2. trap is visible from that same cycle.
- Unmapped access: m_sel at cycle 0, m_ready and trap at cycle 1. No s_sel is asserted.
- s_ready asserted in the same cycle the timeout count is reached: ready wins, no trap.
- All outputs are registered; there is no combinational path from m_* or s_* inputs to any output.

## Structure
- The shared include xdefs.vh gains:
  - XBUS_IDLE, XBUS_WAIT and XBUS_DONE state encodings (2-bit)
  - default slot assignment constants: MEM=0, REGF=1, EXT=2, CPRT=3
- One sub-module, xbus_timer: clear/enable saturating counter with an expired output, parametrised by TIMEOUT. It is tied to constant 0 when TIMEOUT=0.
- The read mux over s_rdata is an indexed part-select on the latched slot, not a priority chain.

## Test plan
- Reset, then write 0xDEADBEEF to addr 0x0805 (slot 1, offset 5), slave ready immediately:
  - s_sel=4'b0010, s_addr=5, s_wdata=0xDEADBEEF at cycle 1
  - m_ready at cycle 2, trap=0
- Read slot 2 with s_ready delayed 3 cycles, s_rdata slot 2 = 0x12345678:
  - m_ready at cycle 5, m_rdata=0x12345678
- Read slot 3 with s_ready never asserted, TIMEOUT=15:
  - s_sel high for cycles 1–16
  - m_ready at cycle 17 with m_rdata=0
  - trap=1, err_slot=3
- N_SLV=3, access to slot 3:
  - m_ready at cycle 1, s_sel=0, trap=1, err_slot=3
  - a second error in slot 0 leaves err_slot=3
- m_sel held high continuously with s_ready always 1:
  - exactly one acceptance every 3 cycles
  - stray s_ready on unselected slots has no effect
- rst asserted during WAIT:
  - next cycle all outputs zero, no m_ready
  - a fresh request completes normally afterward
